// File: rtl/avmm_arb_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avmm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    // A master asserting both strobes is treated as a write.
    function automatic logic read_only(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

endpackage

// File: rtl/avmm_arbiter_2m_rr_pick2.sv
// Two-way round-robin chooser: ties go to the master not served last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       any
);

    // Pick the single requester, or alternate on a tie.
    always_comb begin
        any = req[0] | req[1];
        if (req == 2'b11) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
    end

endmodule

// File: rtl/avmm_arbiter_2m.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant and a
// waitrequest watchdog that aborts stuck transfers.
module avmm_arbiter_2m
    import avmm_arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_address,
    input  logic [DW-1:0] m0_writedata,
    input  logic          m0_read,
    input  logic          m0_write,
    output logic [DW-1:0] m0_readdata,
    output logic          m0_waitrequest,
    input  logic [AW-1:0] m1_address,
    input  logic [DW-1:0] m1_writedata,
    input  logic          m1_read,
    input  logic          m1_write,
    output logic [DW-1:0] m1_readdata,
    output logic          m1_waitrequest,
    output logic [AW-1:0] s_address,
    output logic [DW-1:0] s_writedata,
    output logic          s_read,
    output logic          s_write,
    input  logic [DW-1:0] s_readdata,
    input  logic          s_waitrequest,
    output logic          timeout_err
);

    localparam logic [7:0] WCNT_LAST = 8'(TO_CYCLES - 1);

    arb_state_e    state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic          timeout_err_q, timeout_err_d;

    logic [1:0]    req_s;
    logic          pick_s;
    logic          any_s;
    logic          gnt_read_s;
    logic          gnt_write_s;
    logic [DW-1:0] abort_data_s;

    assign req_s = {m1_read | m1_write, m0_read | m0_write};

    rr_pick2 u_pick (
        .req  (req_s),
        .last (last_q),
        .pick (pick_s),
        .any  (any_s)
    );

    // Next-state logic for the grant FSM and the watchdog counter.
    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_d        = last_q;
        wcnt_d        = wcnt_q;
        timeout_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = GRANT;
                    gnt_d   = pick_s;
                    wcnt_d  = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // A withdrawn request or a slave acceptance both end the transfer.
                if (!req_s[gnt_q] || !s_waitrequest) begin
                    state_d = IDLE;
                    last_d  = gnt_q;
                    wcnt_d  = 8'd0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d       = ABORT;
                    timeout_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            ABORT: begin
                state_d = IDLE;
                last_d  = gnt_q;
                wcnt_d  = 8'd0;
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = 8'd0;
            end
        endcase
    end

    // State registers; reset leaves master 0 winning the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= 1'b0;
            last_q        <= 1'b1;
            wcnt_q        <= 8'd0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_q        <= last_d;
            wcnt_q        <= wcnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Slave-side mux, master-side handshake and read-data steering.
    always_comb begin
        for (int i = 0; i < DW; i++) begin
            abort_data_s[i] = ABORT_DATA[5'(i % 32)];
        end
        gnt_read_s     = gnt_q ? m1_read : m0_read;
        gnt_write_s    = gnt_q ? m1_write : m0_write;
        s_address      = gnt_q ? m1_address : m0_address;
        s_writedata    = gnt_q ? m1_writedata : m0_writedata;
        s_read         = 1'b0;
        s_write        = 1'b0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = s_readdata;
        m1_readdata    = s_readdata;
        case (state_q)
            GRANT: begin
                s_read  = read_only(gnt_read_s, gnt_write_s);
                s_write = gnt_write_s;
                if (gnt_q) begin
                    m1_waitrequest = s_waitrequest;
                end else begin
                    m0_waitrequest = s_waitrequest;
                end
            end
            ABORT: begin
                if (gnt_q) begin
                    m1_waitrequest = 1'b0;
                    m1_readdata    = abort_data_s;
                end else begin
                    m0_waitrequest = 1'b0;
                    m0_readdata    = abort_data_s;
                end
            end
            default: begin
                s_read  = 1'b0;
                s_write = 1'b0;
            end
        endcase
    end

    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_avmm_arbiter_2m.sv
// Directed self-checking bench for avmm_arbiter_2m.
module tb_avmm_arbiter_2m;

    logic        clk;
    logic        reset;
    logic [7:0]  m0_address, m1_address, s_address;
    logic [31:0] m0_writedata, m1_writedata, s_writedata;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_readdata, m1_readdata, s_readdata;
    logic        m0_waitrequest, m1_waitrequest;
    logic        s_read, s_write, s_waitrequest, timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;

    avmm_arbiter_2m #(.AW(8), .DW(32), .TO_CYCLES(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0_address     (m0_address),
        .m0_writedata   (m0_writedata),
        .m0_read        (m0_read),
        .m0_write       (m0_write),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_writedata   (m1_writedata),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .s_address      (s_address),
        .s_writedata    (s_writedata),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_readdata     (s_readdata),
        .s_waitrequest  (s_waitrequest),
        .timeout_err    (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest, timeout_err} !== 5'b00110) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 00110", {s_read, s_write, m0_waitrequest, m1_waitrequest, timeout_err});
        end
        step();
        tests_run++;
        if ({s_read, s_write, m0_waitrequest, m1_waitrequest} !== 4'b0011) begin
            tests_failed++;
            $display("FAIL idle_outputs: got %b expected 0011", {s_read, s_write, m0_waitrequest, m1_waitrequest});
        end
    endtask

    task automatic test_single_read;
        int rd_cycles = 0;
        m0_address = 8'h05; m0_read = 1'b1; s_waitrequest = 1'b1; s_readdata = 32'h0;
        #1;
        tests_run++;
        if (s_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_not_yet_granted: s_read got %b expected 0", s_read);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) begin
                s_waitrequest = 1'b0; s_readdata = 32'h0000_1234;
                #1;
            end
            if (s_read === 1'b1 && s_address === 8'h05) rd_cycles++;
            tests_run++;
            if (m1_waitrequest !== 1'b1 || m0_waitrequest !== s_waitrequest) begin
                tests_failed++;
                $display("FAIL read_waitreq_c%0d: m0 %b m1 %b expected %b 1", k, m0_waitrequest, m1_waitrequest, s_waitrequest);
            end
        end
        tests_run++;
        if (m0_readdata !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL read_data: got %h expected 00001234", m0_readdata);
        end
        tests_run++;
        if (rd_cycles !== 3) begin
            tests_failed++;
            $display("FAIL read_strobe_cycles: got %0d expected 3", rd_cycles);
        end
        step();
        m0_read = 1'b0; s_waitrequest = 1'b1;
        #1;
        tests_run++;
        if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_done_idle: s_read %b m0_wait %b expected 0 1", s_read, m0_waitrequest);
        end
    endtask

    task automatic test_contention;
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_address = 8'h0A; m0_writedata = 32'd20; m0_write = 1'b1;
        m1_address = 8'h0F; m1_writedata = 32'd25; m1_write = 1'b1;
        s_waitrequest = 1'b0;
        step();
        tests_run++;
        if ({s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest} !== {1'b1, 8'h0A, 32'd20, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL contention_first: wr %b addr %h data %0d w0 %b w1 %b expected 1 0a 20 0 1",
                     s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest);
        end
        step();
        m0_write = 1'b0;
        #1;
        tests_run++;
        if ({s_write, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
            tests_failed++;
            $display("FAIL contention_gap: got %b expected 011", {s_write, m0_waitrequest, m1_waitrequest});
        end
        step();
        tests_run++;
        if ({s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest} !== {1'b1, 8'h0F, 32'd25, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL contention_second: wr %b addr %h data %0d w0 %b w1 %b expected 1 0f 25 1 0",
                     s_write, s_address, s_writedata, m0_waitrequest, m1_waitrequest);
        end
        step();
        m1_write = 1'b0;
        #1;
    endtask

    task automatic test_fairness;
        logic exp_g;
        m0_address = 8'h11; m1_address = 8'h22;
        m0_read = 1'b1; m1_read = 1'b1; s_waitrequest = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 1);
            step();
            tests_run++;
            if (s_read !== 1'b1 || s_address !== (exp_g ? 8'h22 : 8'h11) ||
                m0_waitrequest !== exp_g || m1_waitrequest !== !exp_g) begin
                tests_failed++;
                $display("FAIL fairness_grant_%0d: rd %b addr %h w0 %b w1 %b expected grant %0d",
                         i, s_read, s_address, m0_waitrequest, m1_waitrequest, exp_g);
            end
            step();
            tests_run++;
            if (s_read !== 1'b0) begin
                tests_failed++;
                $display("FAIL fairness_idle_%0d: s_read got %b expected 0", i, s_read);
            end
        end
        m0_read = 1'b0; m1_read = 1'b0; s_waitrequest = 1'b1;
        #1;
    endtask

    task automatic test_timeout;
        int grant_cycles = 0;
        int pulses = 0;
        m0_address = 8'h33; m0_read = 1'b1; s_waitrequest = 1'b1; s_readdata = 32'h5555_5555;
        step();
        for (int k = 0; k < 40 && timeout_err !== 1'b1; k++) begin
            if (s_read === 1'b1) grant_cycles++;
            step();
        end
        tests_run++;
        if (grant_cycles !== 16) begin
            tests_failed++;
            $display("FAIL timeout_grant_cycles: got %0d expected 16", grant_cycles);
        end
        tests_run++;
        if ({timeout_err, s_read, m0_waitrequest, m1_waitrequest} !== 4'b1001) begin
            tests_failed++;
            $display("FAIL timeout_abort_ctl: got %b expected 1001", {timeout_err, s_read, m0_waitrequest, m1_waitrequest});
        end
        tests_run++;
        if (m0_readdata !== 32'hDEADBEEF || m1_readdata !== 32'h5555_5555) begin
            tests_failed++;
            $display("FAIL timeout_abort_data: m0 %h m1 %h expected deadbeef 55555555", m0_readdata, m1_readdata);
        end
        pulses = 1;
        step();
        m0_read = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (timeout_err === 1'b1) pulses++;
            step();
        end
        tests_run++;
        if (pulses !== 1 || m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_single_pulse: pulses %0d w0 %b rd %b expected 1 1 0", pulses, m0_waitrequest, s_read);
        end
    endtask

    task automatic test_reset_mid;
        m1_address = 8'h44; m1_writedata = 32'h77; m1_write = 1'b1; s_waitrequest = 1'b1;
        step();
        step();
        reset = 1'b1;
        #1;
        tests_run++;
        if (s_write !== 1'b1 || m1_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_stalled: wr %b w1 %b expected 1 1", s_write, m1_waitrequest);
        end
        step();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({s_write, s_read, m0_waitrequest, m1_waitrequest, timeout_err} !== 5'b00110) begin
            tests_failed++;
            $display("FAIL reset_mid_dropped: got %b expected 00110", {s_write, s_read, m0_waitrequest, m1_waitrequest, timeout_err});
        end
        m0_address = 8'h66; m0_read = 1'b1;
        step();
        s_waitrequest = 1'b0;
        #1;
        tests_run++;
        if ({s_read, s_write, s_address, m0_waitrequest, m1_waitrequest, timeout_err} !== {1'b1, 1'b0, 8'h66, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_mid_tie_m0: rd %b wr %b addr %h w0 %b w1 %b to %b expected 1 0 66 0 1 0",
                     s_read, s_write, s_address, m0_waitrequest, m1_waitrequest, timeout_err);
        end
        step();
        m0_read = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b1;
        step();
    endtask

    task automatic test_read_write_same;
        m1_address = 8'h55; m1_writedata = 32'h0000_CAFE; m1_read = 1'b1; m1_write = 1'b1;
        s_waitrequest = 1'b1;
        step();
        tests_run++;
        if ({s_write, s_read, s_address, s_writedata, m1_waitrequest} !== {1'b1, 1'b0, 8'h55, 32'h0000_CAFE, 1'b1}) begin
            tests_failed++;
            $display("FAIL rw_write_wins: wr %b rd %b addr %h data %h w1 %b expected 1 0 55 0000cafe 1",
                     s_write, s_read, s_address, s_writedata, m1_waitrequest);
        end
        s_waitrequest = 1'b0;
        #1;
        tests_run++;
        if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_accept: w1 %b w0 %b expected 0 1", m1_waitrequest, m0_waitrequest);
        end
        step();
        m1_read = 1'b0; m1_write = 1'b0; s_waitrequest = 1'b1;
        #1;
        tests_run++;
        if (s_write !== 1'b0 || m1_waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL rw_complete: wr %b w1 %b expected 0 1", s_write, m1_waitrequest);
        end
    endtask

    task automatic test_withdraw;
        m0_address = 8'h77; m0_read = 1'b1; s_waitrequest = 1'b1;
        step();
        m0_read = 1'b0;
        #1;
        tests_run++;
        if (s_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL withdraw_strobe: s_read got %b expected 0", s_read);
        end
        step();
        s_waitrequest = 1'b0;
        #1;
        tests_run++;
        if (m0_waitrequest !== 1'b1 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL withdraw_idle: w0 %b to %b expected 1 0", m0_waitrequest, timeout_err);
        end
        s_waitrequest = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        m0_address = 8'h0; m0_writedata = 32'h0; m0_read = 1'b0; m0_write = 1'b0;
        m1_address = 8'h0; m1_writedata = 32'h0; m1_read = 1'b0; m1_write = 1'b0;
        s_readdata = 32'h0; s_waitrequest = 1'b1;
        test_reset();
        test_single_read();
        test_contention();
        test_fairness();
        test_timeout();
        test_reset_mid();
        test_read_write_same();
        test_withdraw();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
